// File: rtl/if_unit_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   InstrWidth : instruction / address width in bits
//   HaltOpcode : default value of Inst[15:12] that stops fetch
//   fetch_state_e : fetch FSM states
package if_unit_pkg;

    localparam int unsigned InstrWidth = 16;
    localparam logic [3:0]  HaltOpcode = 4'hF;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_unit_if_id_reg.sv
// IF/ID pipeline register with its valid bit.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   load              : capture instr_in/pc_in, mark valid
//   hold              : keep contents and valid unchanged
//   clear             : drop valid (contents kept); highest priority
//   instr_in, pc_in   : word and its PC (fetch address + 1)
//   instr_out, pc_out : registered word and PC to decode
//   valid_out         : registered contents are a real instruction
// With none of load/hold/clear asserted the register emits a bubble.
module if_unit_if_id_reg
    import if_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  hold,
    input  logic                  clear,
    input  logic [InstrWidth-1:0] instr_in,
    input  logic [InstrWidth-1:0] pc_in,
    output logic [InstrWidth-1:0] instr_out,
    output logic [InstrWidth-1:0] pc_out,
    output logic                  valid_out
);

    logic [InstrWidth-1:0] instr_q;
    logic [InstrWidth-1:0] pc_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_in;
            pc_q    <= pc_in;
            valid_q <= 1'b1;
        end else if (!hold) begin
            // Nothing to deliver: bubble, data left as-is.
            valid_q <= 1'b0;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/if_unit.sv
// Instruction fetch unit: program counter, one-entry skid buffer, RUN/HALT
// FSM and the IF/ID register.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   stall                       : hold IF/ID (hazard unit)
//   branch_taken, branch_target : redirect fetch and flush younger work
//   imem_req, imem_addr         : fetch request and word address (= pc)
//   imem_rdy, imem_data         : fetch response valid and data
//   instr_out, PC_out, valid_out: IF/ID contents to decode
//   halted                      : high while in the HALT state
module if_unit
    import if_unit_pkg::*;
#(
    parameter logic [InstrWidth-1:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]            HALT_OPCODE = HaltOpcode
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [InstrWidth-1:0] branch_target,
    output logic                  imem_req,
    output logic [InstrWidth-1:0] imem_addr,
    input  logic                  imem_rdy,
    input  logic [InstrWidth-1:0] imem_data,
    output logic [InstrWidth-1:0] instr_out,
    output logic [InstrWidth-1:0] PC_out,
    output logic                  valid_out,
    output logic                  halted
);

    fetch_state_e          state_q, state_d;
    logic [InstrWidth-1:0] pc_q, pc_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [InstrWidth-1:0] buf_instr_q, buf_instr_d;
    logic [InstrWidth-1:0] buf_pc_q, buf_pc_d;

    logic                  accept;
    logic                  fetch_halt;
    logic [InstrWidth-1:0] pc_inc;

    logic                  ifid_load;
    logic                  ifid_hold;
    logic                  ifid_clear;
    logic [InstrWidth-1:0] ifid_instr;
    logic [InstrWidth-1:0] ifid_pc;

    // Request is gated by rst_n so a response during reset is never accepted,
    // and by branch_taken so a same-cycle response is discarded.
    assign imem_req   = rst_n && (state_q == StRun) && !buf_valid_q && !branch_taken;
    assign imem_addr  = pc_q;
    assign accept     = imem_req && imem_rdy;
    assign fetch_halt = (imem_data[InstrWidth-1:InstrWidth-4] == HALT_OPCODE);
    assign pc_inc     = pc_q + 16'd1;  // wraps FFFF -> 0000
    assign halted     = (state_q == StHalt);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        ifid_load   = 1'b0;
        ifid_hold   = 1'b0;
        ifid_clear  = 1'b0;
        ifid_instr  = imem_data;
        ifid_pc     = pc_inc;

        if (branch_taken) begin
            state_d     = StRun;
            pc_d        = branch_target;
            buf_valid_d = 1'b0;
            ifid_clear  = 1'b1;
        end else begin
            ifid_hold = stall;
            if (accept) begin
                // A halt word is still delivered but leaves pc on itself.
                if (fetch_halt) begin
                    state_d = StHalt;
                end else begin
                    pc_d = pc_inc;
                end
                if (stall) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = imem_data;
                    buf_pc_d    = pc_inc;
                end else begin
                    ifid_load = 1'b1;
                end
            end else if (buf_valid_q && !stall) begin
                // Buffer drains in either state; accept implies empty buffer.
                ifid_load   = 1'b1;
                ifid_instr  = buf_instr_q;
                ifid_pc     = buf_pc_q;
                buf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    if_unit_if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifid_load),
        .hold      (ifid_hold),
        .clear     (ifid_clear),
        .instr_in  (ifid_instr),
        .pc_in     (ifid_pc),
        .instr_out (instr_out),
        .pc_out    (PC_out),
        .valid_out (valid_out)
    );

endmodule

// File: tb/tb_if_unit.sv
// Directed bench for if_unit. Stimulus pushes the expected IF/ID contents
// into a queue whenever it sets up an accepted fetch; a monitor pops and
// compares each time the DUT presents a freshly loaded instruction.
module tb_if_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        valid_out;
    logic        halted;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    if_unit #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdy      (imem_rdy),
        .imem_data     (imem_data),
        .instr_out     (instr_out),
        .PC_out        (PC_out),
        .valid_out     (valid_out),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents; unlisted words are opcode 1 with the
    // address in the low 12 bits.
    function automatic logic [15:0] word_at(input logic [15:0] addr);
        case (addr)
            16'h0000: word_at = 16'h1234;
            16'h0001: word_at = 16'h5678;
            16'h0005: word_at = 16'hA001;
            16'h0010: word_at = 16'hF000;
            default:  word_at = {4'h1, addr[11:0]};
        endcase
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [15:0] instr, input logic [15:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    // Monitor: a new IF/ID load is visible as valid_out high after an edge
    // at which stall was low.
    initial begin
        logic stall_prev;
        exp_t e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1 && !stall_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got instr %h pc %h, expected none",
                             instr_out, PC_out);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_instr", {16'h0, instr_out}, {16'h0, e.instr});
                    check("sb_pc", {16'h0, PC_out}, {16'h0, e.pc});
                end
            end
            stall_prev = stall;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_rdy      = 1'b0;
        repeat (3) step();

        check("rst_valid", valid_out, 0);
        check("rst_instr", instr_out, 0);
        check("rst_pc_out", PC_out, 0);
        check("rst_halted", halted, 0);
        check("rst_req_low", imem_req, 0);
        check("rst_addr", imem_addr, 16'h0000);

        // Back-to-back fetch with zero-wait memory.
        rst_n    = 1'b1;
        imem_rdy = 1'b1;
        #1;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 16'h0000);
        expect_out(16'h1234, 16'h0001);
        step();
        check("addr1", imem_addr, 16'h0001);
        expect_out(16'h5678, 16'h0002);
        step();
        check("pc_after_two", imem_addr, 16'h0002);
        check("pc_out_two", PC_out, 16'h0002);
        check("valid_two", valid_out, 1);
        expect_out(16'h1002, 16'h0003);
        step();
        expect_out(16'h1003, 16'h0004);
        step();

        // Three wait cycles at 0x0004.
        imem_rdy = 1'b0;
        #1;
        check("wait1_addr", imem_addr, 16'h0004);
        check("wait1_req", imem_req, 1);
        step();
        check("wait2_addr", imem_addr, 16'h0004);
        check("wait2_bubble", valid_out, 0);
        step();
        check("wait3_addr", imem_addr, 16'h0004);
        check("wait3_bubble", valid_out, 0);
        step();
        check("wait_done_addr", imem_addr, 16'h0004);
        check("wait_done_bubble", valid_out, 0);
        imem_rdy = 1'b1;
        expect_out(16'h1004, 16'h0005);
        step();
        check("single_inc", imem_addr, 16'h0005);

        // Stall during accept of 0xA001 at 0x0005.
        stall = 1'b1;
        expect_out(16'hA001, 16'h0006);
        step();
        check("stall_req_low", imem_req, 0);
        check("stall_hold_instr", instr_out, 16'h1004);
        check("stall_hold_valid", valid_out, 1);
        check("stall_addr", imem_addr, 16'h0006);
        step();
        check("stall2_hold_instr", instr_out, 16'h1004);
        check("stall2_req_low", imem_req, 0);
        stall    = 1'b0;
        imem_rdy = 1'b0;
        step();
        check("drain_instr", instr_out, 16'hA001);
        check("drain_pc", PC_out, 16'h0006);
        check("resume_req", imem_req, 1);
        check("no_refetch", imem_addr, 16'h0006);

        // Branch while stalled with a full buffer.
        stall    = 1'b1;
        imem_rdy = 1'b1;
        step();
        check("buffered_req_low", imem_req, 0);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        #1;
        check("branch_req_low", imem_req, 0);
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        imem_rdy     = 1'b0;
        #1;
        check("branch_flush_valid", valid_out, 0);
        check("branch_addr", imem_addr, 16'h0040);
        check("branch_resume_req", imem_req, 1);
        step();
        check("branch_buf_cleared", valid_out, 0);

        // Response in a branch cycle is discarded.
        imem_rdy      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0010;
        #1;
        check("branch_rdy_req_low", imem_req, 0);
        step();
        branch_taken = 1'b0;
        check("branch2_addr", imem_addr, 16'h0010);
        check("branch2_valid", valid_out, 0);

        // Halt word at 0x0010.
        expect_out(16'hF000, 16'h0011);
        step();
        check("halted_set", halted, 1);
        check("halt_req_low", imem_req, 0);
        check("halt_pc", imem_addr, 16'h0010);
        step();
        check("halt_stays", halted, 1);
        check("halt_pc_hold", imem_addr, 16'h0010);
        branch_taken  = 1'b1;
        branch_target = 16'h0020;
        #1;
        check("halt_in_branch", halted, 1);
        step();
        branch_taken = 1'b0;
        #1;
        check("unhalt", halted, 0);
        check("unhalt_req", imem_req, 1);
        check("unhalt_addr", imem_addr, 16'h0020);
        expect_out(16'h1020, 16'h0021);
        step();

        // PC wrap at 0xFFFF.
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        imem_rdy      = 1'b0;
        step();
        branch_taken = 1'b0;
        imem_rdy     = 1'b1;
        #1;
        check("wrap_start", imem_addr, 16'hFFFF);
        expect_out(16'h1FFF, 16'h0000);
        step();
        check("wrap_pc", imem_addr, 16'h0000);
        check("wrap_pc_out", PC_out, 16'h0000);
        expect_out(16'h1234, 16'h0001);
        step();

        // Reset in the middle of a wait at 0x0001.
        imem_rdy = 1'b0;
        check("pre_rst_addr", imem_addr, 16'h0001);
        step();
        rst_n    = 1'b0;
        imem_rdy = 1'b1;
        #1;
        check("mid_rst_req_low", imem_req, 0);
        step();
        rst_n    = 1'b1;
        imem_rdy = 1'b0;
        #1;
        check("restart_addr", imem_addr, 16'h0000);
        check("restart_valid", valid_out, 0);
        check("restart_req", imem_req, 1);
        imem_rdy = 1'b1;
        expect_out(16'h1234, 16'h0001);
        step();
        imem_rdy = 1'b0;
        step();
        step();
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
